pkt_bufid_dispatch: RTL

//  Shares the central free-bufid FIFO among PORT_NUM network input ports (host, HCP, network).

---
 rtl/tsn_bufid_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 17 +
 rtl/pkt_bufid_dispatch.sv | 82 ++++++++
 3 files changed

// File: rtl/tsn_bufid_pkg.sv
// tsn_bufid_pkg: shared bufid width, dispatch FSM encodings and rotating priority-encoder helper.
package tsn_bufid_pkg;
  localparam int BUFID_W = 9;
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01} state_t;
  // Returns {valid, index} of the first set request at or after ptr, wrapping modulo n (n <= 16).
  function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
    logic [4:0] r;
    r = '0;
    for (int k = 15; k >= 0; k--)
      if (k < n && req[(int'(ptr) + k) % n]) r = {1'b1, 4'((int'(ptr) + k) % n)};
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, grants the first request at or after i_ptr.
module rr_arbiter
  import tsn_bufid_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_gnt_vld,
  output logic [IW-1:0] o_gnt_idx
);
  logic [4:0] w_pick;
  assign w_pick    = rr_pick(16'(i_req), 4'(i_ptr), N);
  assign o_gnt_vld = w_pick[4];
  assign o_gnt_idx = IW'(w_pick[3:0]);
endmodule

// File: rtl/pkt_bufid_dispatch.sv
// pkt_bufid_dispatch: prefetches one free bufid per input port and refills empty slots round-robin.
// Optional per-port grant counters are built when BUFID_DISPATCH_STAT_EN is defined.
module pkt_bufid_dispatch #(
  parameter int PORT_NUM = 8,
  parameter int BUFID_W  = tsn_bufid_pkg::BUFID_W
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          i_free_bufid_empty,
  input  logic [BUFID_W-1:0]            iv_free_bufid,
  output logic                          o_free_bufid_rd,
  input  logic [8:0]                    iv_free_bufid_fifo_rdusedw,
  input  logic [8:0]                    iv_reserve_threshold,
  input  logic [PORT_NUM-1:0]           iv_port_en,
  input  logic [PORT_NUM-1:0]           iv_priority_mask,
  output logic [PORT_NUM-1:0]           ov_pkt_bufid_wr,
  output logic [PORT_NUM*BUFID_W-1:0]   ov_pkt_bufid,
  input  logic [PORT_NUM-1:0]           iv_pkt_bufid_ack,
  output logic [1:0]                    ov_dispatch_state,
  output logic [PORT_NUM*16-1:0]        ov_grant_cnt
);
  import tsn_bufid_pkg::*;
  localparam int IW = PORT_NUM > 1 ? $clog2(PORT_NUM) : 1;
  state_t              r_state, w_next;
  logic [PORT_NUM-1:0] r_slot_full, w_elig, w_ack;
  logic [BUFID_W-1:0]  r_slot_id [PORT_NUM];
  logic [IW-1:0]       r_ptr, r_grant, w_gnt_idx;
  logic                w_gnt_vld, w_above, w_start;
  assign w_above         = iv_free_bufid_fifo_rdusedw >= iv_reserve_threshold;
  assign w_elig          = ~r_slot_full & iv_port_en & ({PORT_NUM{w_above}} | iv_priority_mask);
  assign ov_pkt_bufid_wr = r_slot_full & iv_port_en;
  assign w_ack           = iv_pkt_bufid_ack & ov_pkt_bufid_wr;
  assign w_start         = w_gnt_vld & ~i_free_bufid_empty;
  assign ov_dispatch_state = r_state;
  rr_arbiter #(.N(PORT_NUM), .IW(IW)) u_arb (
    .i_req     (w_elig),
    .i_ptr     (r_ptr),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx)
  );
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE && w_start) ? LOAD : IDLE;
  // The read strobe is combinational so the FIFO data lands exactly in the LOAD cycle.
  always_comb
    o_free_bufid_rd = r_state == IDLE && w_start && !reset;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_slot_full <= '0;
      r_ptr       <= '0;
      r_grant     <= '0;
    end else begin
      if (r_state == IDLE && w_start) r_grant <= w_gnt_idx;
      if (r_state == LOAD) r_ptr <= (int'(r_grant) == PORT_NUM - 1) ? '0 : r_grant + 1'b1;
      r_slot_full <= (r_slot_full & ~w_ack) | (r_state == LOAD ? PORT_NUM'(1) << r_grant : '0);
    end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      for (int p = 0; p < PORT_NUM; p++) r_slot_id[p] <= '0;
    end else if (r_state == LOAD) begin
      r_slot_id[r_grant] <= iv_free_bufid;
    end
  for (genvar g = 0; g < PORT_NUM; g++) begin : g_bus
    assign ov_pkt_bufid[g*BUFID_W +: BUFID_W] = r_slot_id[g];
  end
`ifdef BUFID_DISPATCH_STAT_EN
  logic [15:0] r_grant_cnt [PORT_NUM];
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      for (int p = 0; p < PORT_NUM; p++) r_grant_cnt[p] <= '0;
    end else if (r_state == LOAD) begin
      r_grant_cnt[r_grant] <= r_grant_cnt[r_grant] + 16'd1;
    end
  for (genvar g = 0; g < PORT_NUM; g++) begin : g_cnt
    assign ov_grant_cnt[g*16 +: 16] = r_grant_cnt[g];
  end
`else
  assign ov_grant_cnt = '0;
`endif
endmodule
